uart_rx_fifo: RTL

//  Parametrised UART receiver: configurable data width and runtime parity, start-bit glitch rejection,

---
 rtl/uart_pkg.sv | 5 +
 rtl/sync_fifo.sv | 38 +++
 rtl/uart_rx_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity and receiver state types for the UART receive path
package uart_pkg;
    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO, head reads 0 while empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with glitch rejection, sticky error flags and a receive FIFO
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               RX,
    input  logic [15:0]                        clk_div,
    input  logic [1:0]                         parity_mode,
    input  logic                               rd_en,
    input  logic                               clr_err,
    output logic [DATA_BITS-1:0]               rx_data,
    output logic                               rx_empty,
    output logic                               rx_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_count,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               overrun
);
    rx_state_t            state;
    logic                 rx_meta, rx_s, rx_d;
    logic [15:0]          cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_ok, tick, par_en, stop_tick, push;
    assign tick      = cnt == '0;
    assign par_en    = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
    assign stop_tick = state == STOP && tick;
    assign push      = stop_tick && rx_s && par_ok;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_meta, rx_s, rx_d} <= 3'b111;
        else        {rx_meta, rx_s, rx_d} <= {RX, rx_meta, rx_s};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b1;
        end else if (state == IDLE) begin
            // only a genuine high-to-low edge starts a frame, so a held break never retriggers
            if (rx_d && !rx_s) begin
                state <= START;
                cnt   <= clk_div >> 1;
            end
        end else if (!tick) begin
            cnt <= cnt - 16'd1;
        end else begin
            cnt <= clk_div;
            case (state)
                START: begin
                    state   <= rx_s ? IDLE : DATA;
                    bit_cnt <= '0;
                    par_ok  <= 1'b1;
                end
                DATA: begin
                    shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'(DATA_BITS-1)) state <= par_en ? PARITY : STOP;
                end
                PARITY: begin
                    par_ok <= (^{shreg, rx_s}) == (parity_mode == PAR_ODD);
                    state  <= STOP;
                end
                default: state <= IDLE;
            endcase
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= (stop_tick && !rx_s) || (frame_err && !clr_err);
            parity_err <= (stop_tick && rx_s && !par_ok) || (parity_err && !clr_err);
            overrun    <= (push && rx_full && !rd_en) || (overrun && !clr_err);
        end
    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (rd_en),
        .din   (shreg),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );
endmodule
